// File: rtl/fog_step_decimator.sv
// Step decimator for the FOG loop: windows the signed loop step into a saturating
// sum and queues {seq, sum} in a show-ahead FIFO drained by the CPU.
module fog_step_decimator #(
    parameter int DEPTH = 8,
    parameter int ACC_W = 48
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_trig,
    input  logic [31:0]              i_step,
    input  logic [31:0]              i_dec_n,
    input  logic                     i_clr,
    input  logic                     i_rd,
    output logic [ACC_W-1:0]         o_data,
    output logic [15:0]              o_seq,
    output logic                     o_valid,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_ovf,
    output logic                     o_sat
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [ACC_W-1:0] ACC_MAX_C = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN_C = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [31:0]      win_cnt_q, win_cnt_d;
    logic [31:0]      dec_lat_q, dec_lat_d;
    logic             init_q, init_d;
    logic [15:0]      seq_q, seq_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             sat_q, sat_d;
    logic [ACC_W-1:0] mem_data_q [DEPTH];
    logic [15:0]      mem_seq_q  [DEPTH];

    logic [31:0]      dec_sel_s;
    logic [31:0]      dec_eff_s;
    logic [ACC_W:0]   sum_s;
    logic             pos_clamp_s;
    logic             neg_clamp_s;
    logic [ACC_W-1:0] acc_next_s;
    logic             close_s;
    logic             full_s;
    logic             pop_s;
    logic             push_ok_s;
    logic             we_s;

    // Window arithmetic and FIFO handshake decode
    always_comb begin
        dec_sel_s   = (i_dec_n == 32'd0) ? 32'd1 : i_dec_n;
        // The first cycle after reset release latches the programmed decimation.
        dec_eff_s   = init_q ? dec_sel_s : dec_lat_q;
        sum_s       = {acc_q[ACC_W-1], acc_q} + {{(ACC_W-31){i_step[31]}}, i_step};
        pos_clamp_s = ~sum_s[ACC_W] & sum_s[ACC_W-1];
        neg_clamp_s = sum_s[ACC_W] & ~sum_s[ACC_W-1];
        if (pos_clamp_s) begin
            acc_next_s = ACC_MAX_C;
        end else if (neg_clamp_s) begin
            acc_next_s = ACC_MIN_C;
        end else begin
            acc_next_s = sum_s[ACC_W-1:0];
        end
        close_s   = i_trig && (win_cnt_q == (dec_eff_s - 32'd1));
        full_s    = (count_q == FULL_C);
        pop_s     = i_rd && (count_q != {CW{1'b0}});
        push_ok_s = close_s && (!full_s || pop_s);
        we_s      = push_ok_s && !i_clr;
    end

    // Next-state for window, sequence, FIFO pointers and sticky flags
    always_comb begin
        acc_d     = acc_q;
        win_cnt_d = win_cnt_q;
        dec_lat_d = dec_lat_q;
        init_d    = 1'b0;
        seq_d     = seq_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        sat_d     = sat_q;
        if (i_clr) begin
            acc_d     = {ACC_W{1'b0}};
            win_cnt_d = 32'd0;
            dec_lat_d = dec_sel_s;
            seq_d     = 16'd0;
            wr_ptr_d  = {AW{1'b0}};
            rd_ptr_d  = {AW{1'b0}};
            count_d   = {CW{1'b0}};
            ovf_d     = 1'b0;
            sat_d     = 1'b0;
        end else begin
            if (init_q) begin
                dec_lat_d = dec_sel_s;
            end else begin
                dec_lat_d = dec_lat_q;
            end
            if (i_trig) begin
                if (pos_clamp_s || neg_clamp_s) begin
                    sat_d = 1'b1;
                end else begin
                    sat_d = sat_q;
                end
                if (close_s) begin
                    acc_d     = {ACC_W{1'b0}};
                    win_cnt_d = 32'd0;
                    seq_d     = seq_q + 16'd1;
                    dec_lat_d = dec_sel_s;
                    if (push_ok_s) begin
                        wr_ptr_d = wr_ptr_q + AW'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else begin
                    acc_d     = acc_next_s;
                    win_cnt_d = win_cnt_q + 32'd1;
                end
            end else begin
                acc_d = acc_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_ok_s, pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_q     <= {ACC_W{1'b0}};
            win_cnt_q <= 32'd0;
            dec_lat_q <= 32'd1;
            init_q    <= 1'b1;
            seq_q     <= 16'd0;
            wr_ptr_q  <= {AW{1'b0}};
            rd_ptr_q  <= {AW{1'b0}};
            count_q   <= {CW{1'b0}};
            ovf_q     <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            win_cnt_q <= win_cnt_d;
            dec_lat_q <= dec_lat_d;
            init_q    <= init_d;
            seq_q     <= seq_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            sat_q     <= sat_d;
        end
    end

    // FIFO storage; the head is read straight from the registered array
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_data_q[i] <= {ACC_W{1'b0}};
                mem_seq_q[i]  <= 16'd0;
            end
        end else if (we_s) begin
            mem_data_q[wr_ptr_q] <= acc_next_s;
            mem_seq_q[wr_ptr_q]  <= seq_q;
        end
    end

    assign o_data  = mem_data_q[rd_ptr_q];
    assign o_seq   = mem_seq_q[rd_ptr_q];
    assign o_valid = (count_q != {CW{1'b0}});
    assign o_count = count_q;
    assign o_ovf   = ovf_q;
    assign o_sat   = sat_q;

endmodule

// File: tb/tb_fog_step_decimator.sv
// Bench for fog_step_decimator: a 48-bit and a 34-bit instance share stimulus;
// expected FIFO entries of the 48-bit instance are tracked in a scoreboard queue.
module tb_fog_step_decimator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        trig, clr, rd;
    logic [31:0] step, dec_n;

    logic [47:0] data48;
    logic [15:0] seq48;
    logic        valid48, ovf48, sat48;
    logic [3:0]  count48;
    logic [33:0] data34;
    logic [15:0] seq34;
    logic        valid34, ovf34, sat34;
    logic [3:0]  count34;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [15:0] seq;
        logic [63:0] data;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        bit          trig;
        logic [31:0] step;
        bit          rd;
        bit          ev;
        logic [3:0]  ec;
        logic [63:0] ed;
        logic [15:0] es;
    } vec_t;
    vec_t vt[5];

    fog_step_decimator #(.DEPTH(8), .ACC_W(48)) dut48 (
        .i_clk(clk), .i_rst_n(rst_n), .i_trig(trig), .i_step(step), .i_dec_n(dec_n),
        .i_clr(clr), .i_rd(rd), .o_data(data48), .o_seq(seq48), .o_valid(valid48),
        .o_count(count48), .o_ovf(ovf48), .o_sat(sat48));

    fog_step_decimator #(.DEPTH(8), .ACC_W(34)) dut34 (
        .i_clk(clk), .i_rst_n(rst_n), .i_trig(trig), .i_step(step), .i_dec_n(dec_n),
        .i_clr(clr), .i_rd(rd), .o_data(data34), .o_seq(seq34), .o_valid(valid34),
        .o_count(count34), .o_ovf(ovf34), .o_sat(sat34));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] sx48();
        return {{16{data48[47]}}, data48};
    endfunction

    function automatic logic [63:0] sx34();
        return {{30{data34[33]}}, data34};
    endfunction

    // One clock: drive at negedge, sample at the following negedge.
    task automatic cyc(input bit t, input logic [31:0] s, input bit r, input bit c);
        trig = t; step = s; rd = r; clr = c;
        @(posedge clk);
        @(negedge clk);
        trig = 1'b0; rd = 1'b0; clr = 1'b0;
    endtask

    task automatic pop_chk(input string nm);
        exp_t e;
        chk({nm, "_valid"}, {63'd0, valid48}, 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({nm, "_data"}, sx48(), e.data);
            chk({nm, "_seq"}, {48'd0, seq48}, {48'd0, e.seq});
        end else begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", nm);
        end
        cyc(1'b0, 32'd0, 1'b1, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        rst_n = 1'b0; trig = 1'b0; clr = 1'b0; rd = 1'b0; step = 32'd0; dec_n = 32'd4;
        repeat (3) @(negedge clk);
        chk("rst_data", sx48(), 64'd0);
        chk("rst_seq", {48'd0, seq48}, 64'd0);
        chk("rst_valid", {63'd0, valid48}, 64'd0);
        chk("rst_count", {60'd0, count48}, 64'd0);
        chk("rst_ovf", {63'd0, ovf48}, 64'd0);
        chk("rst_sat", {63'd0, sat48}, 64'd0);
        rst_n = 1'b1;

        // Basic window of four steps, then pop.
        vt[0] = '{1'b1, 32'd10,         1'b0, 1'b0, 4'd0, 64'd0,  16'd0};
        vt[1] = '{1'b1, 32'hFFFF_FFFD,  1'b0, 1'b0, 4'd0, 64'd0,  16'd0};
        vt[2] = '{1'b1, 32'd7,          1'b0, 1'b0, 4'd0, 64'd0,  16'd0};
        vt[3] = '{1'b1, 32'd1,          1'b0, 1'b1, 4'd1, 64'd15, 16'd0};
        vt[4] = '{1'b0, 32'd0,          1'b1, 1'b0, 4'd0, 64'd0,  16'd0};
        for (int i = 0; i < 5; i++) begin
            cyc(vt[i].trig, vt[i].step, vt[i].rd, 1'b0);
            chk($sformatf("t1_valid%0d", i), {63'd0, valid48}, {63'd0, vt[i].ev});
            chk($sformatf("t1_count%0d", i), {60'd0, count48}, {60'd0, vt[i].ec});
            if (vt[i].ev) begin
                chk($sformatf("t1_data%0d", i), sx48(), vt[i].ed);
                chk($sformatf("t1_seq%0d", i), {48'd0, seq48}, {48'd0, vt[i].es});
            end
        end

        // dec_n=0 behaves as 1: fill, overflow, pop.
        dec_n = 32'd0;
        cyc(1'b0, 32'd0, 1'b0, 1'b1);
        sb.delete();
        for (int k = 1; k <= 8; k++) begin
            cyc(1'b1, 32'(k), 1'b0, 1'b0);
            sb.push_back('{16'(k - 1), 64'(k)});
        end
        chk("t2_count_full", {60'd0, count48}, 64'd8);
        chk("t2_ovf_before", {63'd0, ovf48}, 64'd0);
        cyc(1'b1, 32'd9, 1'b0, 1'b0);
        chk("t2_ovf", {63'd0, ovf48}, 64'd1);
        chk("t2_count_ovf", {60'd0, count48}, 64'd8);
        pop_chk("t2_pop");
        chk("t2_head_data", sx48(), 64'd2);
        chk("t2_head_seq", {48'd0, seq48}, 64'd1);

        // Full FIFO with simultaneous push and pop.
        cyc(1'b0, 32'd0, 1'b0, 1'b1);
        sb.delete();
        chk("t3_clr_count", {60'd0, count48}, 64'd0);
        chk("t3_clr_ovf", {63'd0, ovf48}, 64'd0);
        for (int k = 0; k < 8; k++) begin
            cyc(1'b1, 32'(100 + k), 1'b0, 1'b0);
            sb.push_back('{16'(k), 64'(100 + k)});
        end
        e = sb.pop_front();
        chk("t3_head_data", sx48(), e.data);
        chk("t3_head_seq", {48'd0, seq48}, {48'd0, e.seq});
        cyc(1'b1, 32'd200, 1'b1, 1'b0);
        sb.push_back('{16'd8, 64'd200});
        chk("t3_count", {60'd0, count48}, 64'd8);
        chk("t3_ovf", {63'd0, ovf48}, 64'd0);
        for (int k = 0; k < 8; k++) pop_chk($sformatf("t3_drain%0d", k));
        chk("t3_empty", {63'd0, valid48}, 64'd0);

        // Saturation on the 34-bit instance.
        dec_n = 32'd16;
        cyc(1'b0, 32'd0, 1'b0, 1'b1);
        sb.delete();
        for (int k = 0; k < 16; k++) cyc(1'b1, 32'h7FFF_FFFF, 1'b0, 1'b0);
        sb.push_back('{16'd0, 64'd34359738352});
        chk("t4_pos34", sx34(), 64'h0000_0001_FFFF_FFFF);
        chk("t4_sat34", {63'd0, sat34}, 64'd1);
        chk("t4_sat48", {63'd0, sat48}, 64'd0);
        chk("t4_valid34", {63'd0, valid34}, 64'd1);
        pop_chk("t4_pos48");
        cyc(1'b0, 32'd0, 1'b0, 1'b1);
        sb.delete();
        chk("t4_sat34_clr", {63'd0, sat34}, 64'd0);
        for (int k = 0; k < 16; k++) cyc(1'b1, 32'h8000_0000, 1'b0, 1'b0);
        sb.push_back('{16'd0, 64'hFFFF_FFF8_0000_0000});
        chk("t4_neg34", sx34(), 64'hFFFF_FFFE_0000_0000);
        chk("t4_sat34_neg", {63'd0, sat34}, 64'd1);
        pop_chk("t4_neg48");

        // Mid-window change of dec_n applies to the next window.
        dec_n = 32'd3;
        cyc(1'b0, 32'd0, 1'b0, 1'b1);
        sb.delete();
        cyc(1'b1, 32'd5, 1'b0, 1'b0);
        cyc(1'b1, 32'd6, 1'b0, 1'b0);
        dec_n = 32'd2;
        chk("t5_count_pre", {60'd0, count48}, 64'd0);
        cyc(1'b1, 32'd7, 1'b0, 1'b0);
        sb.push_back('{16'd0, 64'd18});
        chk("t5_count_1", {60'd0, count48}, 64'd1);
        cyc(1'b1, 32'd1, 1'b0, 1'b0);
        chk("t5_count_mid", {60'd0, count48}, 64'd1);
        cyc(1'b1, 32'd2, 1'b0, 1'b0);
        sb.push_back('{16'd1, 64'd3});
        chk("t5_count_2", {60'd0, count48}, 64'd2);
        pop_chk("t5_pop0");
        pop_chk("t5_pop1");

        // Clear mid-window with coincident trigger and read.
        dec_n = 32'd1;
        cyc(1'b0, 32'd0, 1'b0, 1'b1);
        sb.delete();
        for (int k = 1; k <= 8; k++) begin
            cyc(1'b1, 32'(k), 1'b0, 1'b0);
            sb.push_back('{16'(k - 1), 64'(k)});
        end
        dec_n = 32'd4;
        cyc(1'b1, 32'd99, 1'b0, 1'b0);
        chk("t6_ovf_set", {63'd0, ovf48}, 64'd1);
        for (int k = 0; k < 5; k++) pop_chk($sformatf("t6_pop%0d", k));
        chk("t6_count3", {60'd0, count48}, 64'd3);
        cyc(1'b1, 32'd50, 1'b0, 1'b0);
        cyc(1'b1, 32'd60, 1'b0, 1'b0);
        cyc(1'b1, 32'd1000, 1'b1, 1'b1);
        sb.delete();
        chk("t6_count", {60'd0, count48}, 64'd0);
        chk("t6_valid", {63'd0, valid48}, 64'd0);
        chk("t6_ovf", {63'd0, ovf48}, 64'd0);
        chk("t6_sat48", {63'd0, sat48}, 64'd0);
        chk("t6_sat34", {63'd0, sat34}, 64'd0);
        for (int k = 0; k < 3; k++) cyc(1'b1, 32'd1, 1'b0, 1'b0);
        chk("t6_count_mid", {60'd0, count48}, 64'd0);
        cyc(1'b1, 32'd1, 1'b0, 1'b0);
        sb.push_back('{16'd0, 64'd4});
        chk("t6_count_after", {60'd0, count48}, 64'd1);
        pop_chk("t6_post");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
